// File: rtl/cpunc_axi_mem_slave.sv
// Single-beat AXI-style memory slave: independent write (AW/W/B) and read (AR/R) FSMs
// over a word-addressed byte-strobed RAM, with a configurable read latency.
module cpunc_axi_mem_slave #(
    parameter int MEM_POWER_SIZE = 12,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = MEM_POWER_SIZE,
    parameter int AXI_MASK_WIDTH = AXI_DATA_WIDTH/8,
    parameter int RD_WAIT        = 1
) (
    input  logic                      CPUNC_ACLK,
    input  logic                      CPUNC_ARESET,
    input  logic [7:0]                CPUNC_AWID,
    input  logic [AXI_ADDR_WIDTH-1:0] CPUNC_AWADDR,
    input  logic [7:0]                CPUNC_AWLN,
    input  logic [1:0]                CPUNC_AWSIZE,
    input  logic [1:0]                CPUNC_AWBURST,
    input  logic                      CPUNC_AWLOCK,
    input  logic [2:0]                CPUNC_AWCACHE,
    input  logic                      CPUNC_AWPROT,
    input  logic [2:0]                CPUNC_AWQOS,
    input  logic                      CPUNC_AWVALID,
    output logic                      CPUNC_AWREADY,
    input  logic [7:0]                CPUNC_WID,
    input  logic [AXI_DATA_WIDTH-1:0] CPUNC_WDATA,
    input  logic [AXI_MASK_WIDTH-1:0] CPUNC_WSTRB,
    input  logic                      CPUNC_WLAST,
    input  logic                      CPUNC_WVALID,
    output logic                      CPUNC_WREADY,
    output logic [7:0]                CPUNC_BID,
    output logic                      CPUNC_BRESP,
    output logic                      CPUNC_BVALID,
    input  logic                      CPUNC_BREADY,
    input  logic [7:0]                CPUNC_ARID,
    input  logic [AXI_ADDR_WIDTH-1:0] CPUNC_ARADDR,
    input  logic [7:0]                CPUNC_ARLN,
    input  logic [1:0]                CPUNC_ARSIZE,
    input  logic [1:0]                CPUNC_ARBURST,
    input  logic                      CPUNC_ARLOCK,
    input  logic [2:0]                CPUNC_ARCACHE,
    input  logic                      CPUNC_ARPROT,
    input  logic [2:0]                CPUNC_ARQOS,
    input  logic                      CPUNC_ARVALID,
    output logic                      CPUNC_ARREADY,
    output logic [7:0]                CPUNC_RID,
    output logic [AXI_DATA_WIDTH-1:0] CPUNC_RDATA,
    output logic                      CPUNC_RRESP,
    output logic                      CPUNC_RLAST,
    output logic                      CPUNC_RVALID,
    input  logic                      CPUNC_RREADY
);
    localparam int IDX_W = MEM_POWER_SIZE - 2;
    localparam int DEPTH = 1 << IDX_W;
    localparam logic [3:0] WAIT_INIT = 4'(RD_WAIT - 1);

    typedef enum logic [1:0] {W_IDLE, W_WAIT_W, W_WAIT_A, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} rstate_t;

    logic [AXI_DATA_WIDTH-1:0] mem [DEPTH];

    // ---------------- write side ----------------
    wstate_t                   ws, ws_nxt;
    logic [IDX_W-1:0]          w_idx_q;
    logic                      w_lenerr_q;
    logic [7:0]                bid_q;
    logic [AXI_DATA_WIDTH-1:0] wdata_q;
    logic [AXI_MASK_WIDTH-1:0] wstrb_q;
    logic                      wlast_q;
    logic                      bresp_q;
    logic                      aw_hs, w_hs, wr_commit, wr_err, mem_we;
    logic [IDX_W-1:0]          cur_widx;
    logic                      cur_wlenerr, cur_wlast;
    logic [AXI_DATA_WIDTH-1:0] cur_wdata;
    logic [AXI_MASK_WIDTH-1:0] cur_wstrb;

    always_comb begin
        ws_nxt        = ws;
        CPUNC_AWREADY = 1'b0;
        CPUNC_WREADY  = 1'b0;
        CPUNC_BVALID  = 1'b0;
        case (ws)
            W_IDLE: begin
                CPUNC_AWREADY = 1'b1;
                CPUNC_WREADY  = 1'b1;
                if (CPUNC_AWVALID && CPUNC_WVALID) ws_nxt = W_RESP;
                else if (CPUNC_AWVALID)            ws_nxt = W_WAIT_W;
                else if (CPUNC_WVALID)             ws_nxt = W_WAIT_A;
            end
            W_WAIT_W: begin
                CPUNC_WREADY = 1'b1;
                if (CPUNC_WVALID) ws_nxt = W_RESP;
            end
            W_WAIT_A: begin
                CPUNC_AWREADY = 1'b1;
                if (CPUNC_AWVALID) ws_nxt = W_RESP;
            end
            W_RESP: begin
                CPUNC_BVALID = 1'b1;
                if (CPUNC_BREADY) ws_nxt = W_IDLE;
            end
            default: ws_nxt = W_IDLE;
        endcase
    end

    assign aw_hs = CPUNC_AWVALID && CPUNC_AWREADY;
    assign w_hs  = CPUNC_WVALID && CPUNC_WREADY;

    // Whichever half arrives on the committing edge comes straight from the bus
    assign cur_widx    = aw_hs ? CPUNC_AWADDR[MEM_POWER_SIZE-1:2] : w_idx_q;
    assign cur_wlenerr = aw_hs ? (CPUNC_AWLN != 8'd0) : w_lenerr_q;
    assign cur_wdata   = w_hs ? CPUNC_WDATA : wdata_q;
    assign cur_wstrb   = w_hs ? CPUNC_WSTRB : wstrb_q;
    assign cur_wlast   = w_hs ? CPUNC_WLAST : wlast_q;

    assign wr_commit = !CPUNC_ARESET && (ws != W_RESP) && (ws_nxt == W_RESP);
    assign wr_err    = cur_wlenerr || !cur_wlast;
    assign mem_we    = wr_commit && !wr_err;

    always_ff @(posedge CPUNC_ACLK) begin
        if (CPUNC_ARESET) begin
            ws         <= W_IDLE;
            w_idx_q    <= '0;
            w_lenerr_q <= 1'b0;
            bid_q      <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            wlast_q    <= 1'b0;
            bresp_q    <= 1'b0;
        end else begin
            ws <= ws_nxt;
            if (aw_hs) begin
                w_idx_q    <= CPUNC_AWADDR[MEM_POWER_SIZE-1:2];
                w_lenerr_q <= (CPUNC_AWLN != 8'd0);
                bid_q      <= CPUNC_AWID;
            end
            if (w_hs) begin
                wdata_q <= CPUNC_WDATA;
                wstrb_q <= CPUNC_WSTRB;
                wlast_q <= CPUNC_WLAST;
            end
            if (wr_commit) bresp_q <= wr_err;
        end
    end

    // Memory is deliberately outside the reset domain
    always_ff @(posedge CPUNC_ACLK) begin
        if (mem_we) begin
            for (int i = 0; i < AXI_MASK_WIDTH; i++)
                if (cur_wstrb[i]) mem[cur_widx][8*i +: 8] <= cur_wdata[8*i +: 8];
        end
    end

    assign CPUNC_BID   = bid_q;
    assign CPUNC_BRESP = bresp_q;

    // ---------------- read side ----------------
    rstate_t                   rs, rs_nxt;
    logic [IDX_W-1:0]          r_idx_q, cur_ridx;
    logic                      r_lenerr_q, cur_rlenerr;
    logic [7:0]                rid_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_q;
    logic                      rresp_q;
    logic [3:0]                cnt;
    logic                      ar_hs, enter_r;

    always_comb begin
        rs_nxt        = rs;
        CPUNC_ARREADY = 1'b0;
        CPUNC_RVALID  = 1'b0;
        CPUNC_RLAST   = 1'b0;
        case (rs)
            R_IDLE: begin
                CPUNC_ARREADY = 1'b1;
                if (CPUNC_ARVALID) rs_nxt = (RD_WAIT == 1) ? R_DATA : R_WAIT;
            end
            R_WAIT: if (cnt == 4'd1) rs_nxt = R_DATA;
            R_DATA: begin
                CPUNC_RVALID = 1'b1;
                CPUNC_RLAST  = 1'b1;
                if (CPUNC_RREADY) rs_nxt = R_IDLE;
            end
            default: rs_nxt = R_IDLE;
        endcase
    end

    assign ar_hs       = CPUNC_ARVALID && CPUNC_ARREADY;
    assign cur_ridx    = ar_hs ? CPUNC_ARADDR[MEM_POWER_SIZE-1:2] : r_idx_q;
    assign cur_rlenerr = ar_hs ? (CPUNC_ARLN != 8'd0) : r_lenerr_q;
    assign enter_r     = (rs != R_DATA) && (rs_nxt == R_DATA);

    always_ff @(posedge CPUNC_ACLK) begin
        if (CPUNC_ARESET) begin
            rs         <= R_IDLE;
            r_idx_q    <= '0;
            r_lenerr_q <= 1'b0;
            rid_q      <= '0;
            rdata_q    <= '0;
            rresp_q    <= 1'b0;
            cnt        <= '0;
        end else begin
            rs <= rs_nxt;
            if (ar_hs) begin
                r_idx_q    <= CPUNC_ARADDR[MEM_POWER_SIZE-1:2];
                r_lenerr_q <= (CPUNC_ARLN != 8'd0);
                rid_q      <= CPUNC_ARID;
                cnt        <= WAIT_INIT;
            end else if (rs == R_WAIT) begin
                cnt <= cnt - 4'd1;
            end
            // Non-blocking read: a write landing on this same edge is not seen
            if (enter_r) begin
                rdata_q <= cur_rlenerr ? '0 : mem[cur_ridx];
                rresp_q <= cur_rlenerr;
            end
        end
    end

    assign CPUNC_RID   = rid_q;
    assign CPUNC_RDATA = rdata_q;
    assign CPUNC_RRESP = rresp_q;

    logic unused_inputs;
    assign unused_inputs = ^{CPUNC_WID, CPUNC_AWSIZE, CPUNC_AWBURST, CPUNC_AWLOCK, CPUNC_AWCACHE,
                             CPUNC_AWPROT, CPUNC_AWQOS, CPUNC_ARSIZE, CPUNC_ARBURST, CPUNC_ARLOCK,
                             CPUNC_ARCACHE, CPUNC_ARPROT, CPUNC_ARQOS, CPUNC_AWADDR[1:0],
                             CPUNC_ARADDR[1:0]};
endmodule
